// File: rtl/fuente_pulsos_conteo_pkg.sv
// Shared definitions for the counter clock-source producer.
// Holds the default timing constants (derived from the system clock rate),
// the source-select encoding and a counter-width helper.
package fuente_pulsos_conteo_pkg;

  localparam int CLK_HZ          = 50_000_000;
  localparam int DEF_DIV_COUNT   = CLK_HZ / 10;   // 10 Hz tick
  localparam int DEF_DEB_COUNT   = CLK_HZ / 100;  // 10 ms debounce window
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic {
    SRC_AUTO   = 1'b0,
    SRC_MANUAL = 1'b1
  } src_e;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fuente_pulsos_conteo_debounce_sync.sv
// debounce_sync: synchroniser chain followed by a stable-count debouncer.
//   clk      system clock
//   rst      synchronous active-high reset
//   din_i    raw asynchronous input
//   level_o  debounced level; changes DEB_COUNT cycles after the
//            synchronised input settles at a new value
//   rise_o   one-cycle pulse in the first cycle level_o reads 1
module debounce_sync
  import fuente_pulsos_conteo_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEB_COUNT   = DEF_DEB_COUNT
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic level_o,
  output logic rise_o
);

  localparam int              CW       = cnt_width(DEB_COUNT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_COUNT - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   din_s;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], din_i};
    din_s   = sync_q[SYNC_STAGES-1];
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (din_s != level_q) begin
      // Last stable cycle reached: commit the new level and restart.
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
        rise_d  = ~level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/fuente_pulsos_conteo.sv
// fuente_pulsos_conteo: produces the single-cycle count enable for the
// BCD counter from either a free-running 10 Hz divider or a debounced
// pushbutton, chosen by a debounced slide switch.
//   clk        system clock
//   rst        synchronous active-high reset
//   pulsa      raw pushbutton (1 = pressed)
//   selector   raw slide switch (0 = auto tick, 1 = manual button)
//   step_en    registered one-cycle count enable
//   tick10     one-cycle pulse every DIV_COUNT cycles
//   btn_level  debounced button level
//   src_sel    debounced, effective selector value
module fuente_pulsos_conteo
  import fuente_pulsos_conteo_pkg::*;
#(
  parameter int DIV_COUNT   = DEF_DIV_COUNT,
  parameter int DEB_COUNT   = DEF_DEB_COUNT,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic pulsa,
  input  logic selector,
  output logic step_en,
  output logic tick10,
  output logic btn_level,
  output logic src_sel
);

  localparam int            DW       = cnt_width(DIV_COUNT);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV_COUNT - 1);

  logic [DW-1:0] cnt_div_q, cnt_div_d;
  logic          step_en_q, step_en_d;
  logic          sel_prev_q;
  logic          btn_pulse;
  logic          sel_rise_unused;
  logic          sel_fall;
  logic          tick;
  logic          src_pulse;

  debounce_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_COUNT   (DEB_COUNT)
  ) u_btn (
    .clk     (clk),
    .rst     (rst),
    .din_i   (pulsa),
    .level_o (btn_level),
    .rise_o  (btn_pulse)
  );

  // Entering manual mode needs no special edge handling: the tick path is
  // deselected by the mux itself, and a button held through reset must still
  // produce its single step when both debouncers settle on the same cycle.
  debounce_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_COUNT   (DEB_COUNT)
  ) u_sel (
    .clk     (clk),
    .rst     (rst),
    .din_i   (selector),
    .level_o (src_sel),
    .rise_o  (sel_rise_unused)
  );

  always_comb begin
    tick      = (cnt_div_q == DIV_LAST);
    sel_fall  = sel_prev_q & ~src_sel;
    cnt_div_d = tick ? '0 : cnt_div_q + DW'(1);
    // Restart the divider on return to auto so the first auto step is a
    // full period away; the tick of the switch cycle itself is dropped.
    if (sel_fall) begin
      cnt_div_d = '0;
    end
    src_pulse = (src_e'(src_sel) == SRC_MANUAL) ? btn_pulse : tick;
    step_en_d = src_pulse & ~sel_fall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_div_q  <= '0;
      step_en_q  <= 1'b0;
      sel_prev_q <= 1'b0;
    end else begin
      cnt_div_q  <= cnt_div_d;
      step_en_q  <= step_en_d;
      sel_prev_q <= src_sel;
    end
  end

  assign step_en = step_en_q;
  assign tick10  = tick;

endmodule

// File: tb/tb_fuente_pulsos_conteo.sv
module tb_fuente_pulsos_conteo;

  localparam int DIV_COUNT   = 10;
  localparam int DEB_COUNT   = 4;
  localparam int SYNC_STAGES = 2;

  logic clk = 1'b0;
  logic rst, pulsa, selector;
  logic step_en, tick10, btn_level, src_sel;

  int n_checks = 0;
  int n_errors = 0;

  fuente_pulsos_conteo #(
    .DIV_COUNT   (DIV_COUNT),
    .DEB_COUNT   (DEB_COUNT),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pulsa     (pulsa),
    .selector  (selector),
    .step_en   (step_en),
    .tick10    (tick10),
    .btn_level (btn_level),
    .src_sel   (src_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Wait for a tick (bounded), then advance so the next tick lands
  // 'lead' cycles after the caller's next input change.
  task automatic align_tick(input string tag, input int lead);
    int w;
    w = 0;
    while (tick10 !== 1'b1 && w < 2 * DIV_COUNT) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_tick_seen"}, tick10, 1'b1);
    repeat (DIV_COUNT - lead) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; selector = 1'b0; pulsa = 1'b0;

    // 1: reset, then auto mode
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("rst_step_en_%0d", k), step_en, 1'b0);
      check($sformatf("rst_tick_%0d", k), tick10, 1'b0);
      check($sformatf("rst_btn_%0d", k), btn_level, 1'b0);
      check($sformatf("rst_sel_%0d", k), src_sel, 1'b0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      check($sformatf("t1_tick_%0d", k), tick10, (k % 10) == 9);
      check($sformatf("t1_step_%0d", k), step_en, (k >= 10) && ((k % 10) == 0));
    end

    // 2: switch to manual (tick at k=8 must be ignored), clean press
    selector = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("t2_sel_%0d", k), src_sel, k >= 6);
      check($sformatf("t2_tick_%0d", k), tick10, k == 8);
      check($sformatf("t2_step_idle_%0d", k), step_en, 1'b0);
    end
    pulsa = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check($sformatf("t2_btn_%0d", k), btn_level, k >= 6);
      check($sformatf("t2_step_%0d", k), step_en, k == 7);
    end
    pulsa = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("t2_rel_btn_%0d", k), btn_level, k < 6);
      check($sformatf("t2_rel_step_%0d", k), step_en, 1'b0);
    end

    // 3: bouncing press
    for (int k = 0; k < 12; k++) begin
      pulsa = ((k / 2) % 2) == 0;
      @(negedge clk);
      check($sformatf("t3_bounce_btn_%0d", k), btn_level, 1'b0);
      check($sformatf("t3_bounce_step_%0d", k), step_en, 1'b0);
    end
    pulsa = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("t3_btn_%0d", k), btn_level, k >= 6);
      check($sformatf("t3_step_%0d", k), step_en, k == 7);
    end
    pulsa = 1'b0;
    repeat (8) @(negedge clk);
    check("t3_released", btn_level, 1'b0);

    // 4: back to auto mid-count; divider restarts on the switch
    align_tick("t4", 4);
    selector = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check($sformatf("t4_sel_%0d", k), src_sel, k < 6);
      check($sformatf("t4_tick_%0d", k), tick10, (k == 4) || (k == 16));
      check($sformatf("t4_step_%0d", k), step_en, k == 17);
    end

    // 5: button press in auto mode only follows tick cadence
    repeat (3) @(negedge clk);
    pulsa = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("t5_btn_%0d", k), btn_level, k >= 6);
      check($sformatf("t5_step_%0d", k), step_en, (k == 4) || (k == 14));
    end
    pulsa = 1'b0;
    repeat (8) @(negedge clk);
    check("t5_released", btn_level, 1'b0);

    // 6: manual mode, reset pulsed mid-press
    selector = 1'b1;
    repeat (10) @(negedge clk);
    check("t6_sel_manual", src_sel, 1'b1);
    pulsa = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_step", step_en, 1'b0);
    check("t6_rst_tick", tick10, 1'b0);
    check("t6_rst_btn", btn_level, 1'b0);
    check("t6_rst_sel", src_sel, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("t6_btn_%0d", k), btn_level, k >= 6);
      check($sformatf("t6_sel_%0d", k), src_sel, k >= 6);
      check($sformatf("t6_step_%0d", k), step_en, k == 7);
    end

    // 7: tick coinciding with the switch-to-auto cycle is dropped
    align_tick("t7", 6);
    selector = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check($sformatf("t7_sel_%0d", k), src_sel, k < 6);
      check($sformatf("t7_tick_%0d", k), tick10, (k == 6) || (k == 16));
      check($sformatf("t7_step_%0d", k), step_en, k == 17);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
